// File: rtl/dot_product_seq.sv
// Sequenced multiply-accumulate front-end: folds a stream of signed operand
// pairs into a running sum and emits one dot product per VEC_LEN pairs.
module dot_product_seq #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH,
  parameter int VEC_LEN    = 4,
  parameter int CNT_WIDTH  = $clog2(VEC_LEN)+1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_a,
  input  logic signed [DATA_WIDTH-1:0] in_b,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  out_data,
  output logic [CNT_WIDTH-1:0]         beat_cnt,
  output logic                         err_last
);

  typedef enum logic {S_FIRST, S_ACC} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(VEC_LEN-1);

  state_t                         r_state;
  logic signed [ACC_WIDTH-1:0]    r_acc;
  logic signed [ACC_WIDTH-1:0]    r_out_data;
  logic                           r_out_valid;
  logic                           r_err_last;
  logic [CNT_WIDTH-1:0]           r_beat_cnt;

  logic                           w_accept;
  logic                           w_out_take;
  logic                           w_is_last;
  logic signed [2*DATA_WIDTH-1:0] w_prod_full;
  logic signed [ACC_WIDTH-1:0]    w_prod;
  logic signed [ACC_WIDTH-1:0]    w_sum;

  // A stalled result blocks new beats, which freezes the accumulator for free.
  assign in_ready    = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_out_take  = r_out_valid && out_ready;
  assign w_is_last   = (r_beat_cnt == LAST_CNT);
  assign w_prod_full = in_a * in_b;
  assign w_prod      = ACC_WIDTH'(w_prod_full);
  assign w_sum       = (r_state == S_FIRST) ? w_prod : r_acc + w_prod;

  // NOTE: non-blocking assignments throughout, so a later "set" of
  // r_out_valid in the same edge overrides the earlier "clear" cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FIRST;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_err_last  <= 1'b0;
      r_beat_cnt  <= '0;
    end else begin
      if (w_out_take) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (in_last != w_is_last) begin
          r_err_last <= 1'b1;
        end
        // The beat count alone frames vectors; in_last only feeds the error flag.
        if (w_is_last) begin
          r_out_data  <= w_sum;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_beat_cnt  <= '0;
          r_state     <= S_FIRST;
        end else begin
          r_acc       <= w_sum;
          r_beat_cnt  <= r_beat_cnt + 1'b1;
          r_state     <= S_ACC;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign beat_cnt  = r_beat_cnt;
  assign err_last  = r_err_last;

endmodule

// File: tb/tb_dot_product_seq.sv
// Bench for dot_product_seq: a VEC_LEN=3 and a VEC_LEN=4 instance, each checked
// every cycle against a sum/count reference, plus hand-computed directed results.
module tb_dot_product_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               in_valid [2];
  logic               in_ready [2];
  logic signed [15:0] in_a     [2];
  logic signed [15:0] in_b     [2];
  logic               in_last  [2];
  logic               out_valid[2];
  logic               out_ready[2];
  logic        [31:0] out_data [2];
  logic         [2:0] beat_cnt [2];
  logic               err_last [2];

  dot_product_seq #(.DATA_WIDTH(16), .VEC_LEN(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .beat_cnt(beat_cnt[0]), .err_last(err_last[0])
  );

  dot_product_seq #(.DATA_WIDTH(16), .VEC_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .beat_cnt(beat_cnt[1]), .err_last(err_last[1])
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)",
               name, act, $signed(act), exp, $signed(exp));
    end
  endtask

  function automatic int vlen(input int k);
    return (k == 0) ? 3 : 4;
  endfunction

  // Reference: pairs seen so far in the vector, their wrapped sum, pending result.
  int          m_cnt  [2];
  logic [31:0] m_sum  [2];
  logic [31:0] m_data [2];
  logic        m_valid[2];
  logic        m_err  [2];
  bit          started = 1'b0;
  int          cycle   = 0;

  logic [31:0] res_log[2][32];
  int          res_cyc[2][32];
  int          n_res  [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_sum[k] = '0; m_data[k] = '0; m_valid[k] = 1'b0; m_err[k] = 1'b0;
      n_res[k] = 0;
    end
  end

  // Compare against the reference, then advance it over the coming rising edge.
  always @(negedge clk) begin
    cycle++;
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("u%0d out_valid", k), 32'(out_valid[k]), 32'(m_valid[k]));
        check($sformatf("u%0d in_ready", k), 32'(in_ready[k]), 32'(!m_valid[k] || out_ready[k]));
        check($sformatf("u%0d beat_cnt", k), 32'(beat_cnt[k]), 32'(m_cnt[k]));
        check($sformatf("u%0d err_last", k), 32'(err_last[k]), 32'(m_err[k]));
        if (m_valid[k]) begin
          check($sformatf("u%0d out_data", k), out_data[k], m_data[k]);
        end
        if (out_valid[k] && out_ready[k] && n_res[k] < 32) begin
          res_log[k][n_res[k]] = out_data[k];
          res_cyc[k][n_res[k]] = cycle;
          n_res[k]++;
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_cnt[k] = 0; m_sum[k] = '0; m_data[k] = '0; m_valid[k] = 1'b0; m_err[k] = 1'b0;
      end else begin
        bit take;
        bit acc;
        int p;
        take = m_valid[k] && out_ready[k];
        acc  = in_valid[k] && (!m_valid[k] || out_ready[k]);
        if (take) m_valid[k] = 1'b0;
        if (acc) begin
          p = int'(in_a[k]) * int'(in_b[k]);
          if (in_last[k] != (m_cnt[k] == vlen(k) - 1)) m_err[k] = 1'b1;
          if (m_cnt[k] == vlen(k) - 1) begin
            m_data[k]  = m_sum[k] + 32'(p);
            m_valid[k] = 1'b1;
            m_sum[k]   = '0;
            m_cnt[k]   = 0;
          end else begin
            m_sum[k] = m_sum[k] + 32'(p);
            m_cnt[k] = m_cnt[k] + 1;
          end
        end
      end
    end
    if (rst) started = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pair (called just after a rising edge) and hold it until accepted.
  task automatic send(input int k, input logic signed [15:0] a, input logic signed [15:0] b,
                      input logic last, output int waited);
    in_valid[k] = 1'b1;
    in_a[k]     = a;
    in_b[k]     = b;
    in_last[k]  = last;
    waited      = 0;
    forever begin
      @(negedge clk);
      if (in_ready[k]) break;
      waited++;
      if (waited > 50) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send timeout u%0d: in_ready stayed 0 for %0d cycles, required 1", k, waited);
        break;
      end
    end
    step();
  endtask

  task automatic idle(input int k);
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
  endtask

  function automatic logic [15:0] rnd_op();
    case ($urandom_range(0, 3))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int w;
    int waits;
    int n0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; in_a[k] = '0; in_b[k] = '0; in_last[k] = 1'b0; out_ready[k] = 1'b1;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset out_valid", 32'(out_valid[k]), 32'd0);
      check("reset out_data", out_data[k], 32'd0);
      check("reset beat_cnt", 32'(beat_cnt[k]), 32'd0);
      check("reset err_last", 32'(err_last[k]), 32'd0);
      check("reset in_ready", 32'(in_ready[k]), 32'd1);
    end
    step();

    // Basic vector: 50 - 12 - 56 = -18, valid for exactly one cycle.
    send(0, 10, 5, 1'b0, w);
    send(0, -3, 4, 1'b0, w);
    send(0, 7, -8, 1'b1, w);
    idle(0);
    @(negedge clk);
    check("basic out_valid", 32'(out_valid[0]), 32'd1);
    check("basic out_data", out_data[0], -32'sd18);
    check("basic err_last", 32'(err_last[0]), 32'd0);
    @(negedge clk);
    check("basic one-cycle valid", 32'(out_valid[0]), 32'd0);
    step();

    // Wraparound: 4 * 2^30 mod 2^32 = 0; 4 * 0x3FFF0001 = 0xFFFC0004.
    for (int i = 0; i < 4; i++) send(1, -16'sd32768, -16'sd32768, i == 3, w);
    idle(1);
    @(negedge clk);
    check("wrap neg out_valid", 32'(out_valid[1]), 32'd1);
    check("wrap neg out_data", out_data[1], 32'd0);
    step();
    for (int i = 0; i < 4; i++) send(1, 16'sd32767, 16'sd32767, i == 3, w);
    idle(1);
    @(negedge clk);
    check("wrap pos out_data", out_data[1], 32'hFFFC0004);
    step();

    // Backpressure: a stalled result holds and blocks further beats.
    out_ready[0] = 1'b0;
    send(0, 10, 5, 1'b0, w);
    send(0, -3, 4, 1'b0, w);
    send(0, 7, -8, 1'b1, w);
    idle(0);
    @(negedge clk);
    check("stall out_data", out_data[0], -32'sd18);
    step();
    in_valid[0] = 1'b1; in_a[0] = 1; in_b[0] = 1; in_last[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall hold out_data", out_data[0], -32'sd18);
      check("stall hold out_valid", 32'(out_valid[0]), 32'd1);
      check("stall in_ready", 32'(in_ready[0]), 32'd0);
      check("stall beat_cnt", 32'(beat_cnt[0]), 32'd0);
    end
    step();
    out_ready[0] = 1'b1;
    send(0, 1, 1, 1'b0, w);
    send(0, 1, 1, 1'b0, w);
    send(0, 1, 1, 1'b1, w);
    idle(0);
    @(negedge clk);
    check("after stall out_data", out_data[0], 32'd3);
    step();

    // Back-to-back vectors: 6 then 12, three cycles apart, no bubble.
    n0 = n_res[0];
    waits = 0;
    for (int i = 0; i < 6; i++) begin
      send(0, (i < 3) ? 16'sd1 : 16'sd2, 16'sd2, (i % 3) == 2, w);
      waits += w;
    end
    idle(0);
    repeat (2) @(negedge clk);
    check("stream first", res_log[0][n0], 32'd6);
    check("stream second", res_log[0][n0+1], 32'd12);
    check("stream spacing", 32'(res_cyc[0][n0+1] - res_cyc[0][n0]), 32'd3);
    check("stream in_ready waits", 32'(waits), 32'd0);
    step();

    // Reset mid-vector discards the partial sum: -56 + 1 + 1 = -54.
    send(0, 10, 5, 1'b0, w);
    send(0, -3, 4, 1'b0, w);
    idle(0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midreset out_valid", 32'(out_valid[0]), 32'd0);
    check("midreset beat_cnt", 32'(beat_cnt[0]), 32'd0);
    step();
    n0 = n_res[0];
    send(0, 7, -8, 1'b0, w);
    send(0, 1, 1, 1'b0, w);
    send(0, 1, 1, 1'b1, w);
    idle(0);
    repeat (2) @(negedge clk);
    check("midreset result", res_log[0][n0], -32'sd54);
    check("midreset result count", 32'(n_res[0] - n0), 32'd1);
    step();

    // Early in_last: sticky error, framing still by count, sum still correct.
    n0 = n_res[0];
    send(0, 1, 1, 1'b0, w);
    send(0, 1, 1, 1'b1, w);
    idle(0);
    @(negedge clk);
    check("frame err set", 32'(err_last[0]), 32'd1);
    check("frame no early result", 32'(out_valid[0]), 32'd0);
    step();
    send(0, 1, 1, 1'b0, w);
    idle(0);
    repeat (2) @(negedge clk);
    check("frame result", res_log[0][n0], 32'd3);
    check("frame err sticky", 32'(err_last[0]), 32'd1);
    step();

    // Randomized traffic on both instances, checked every cycle by the reference.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        in_a[k]      = rnd_op();
        in_b[k]      = rnd_op();
        in_last[k]   = ($urandom_range(0, 3) == 0);
        out_ready[k] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      idle(k);
      out_ready[k] = 1'b1;
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dot_product_seq.md
Name: dot_product_seq

Overview:
- Synthesizable sequencer that drives a multiply-accumulate datapath and returns a finished dot product.
- Accepts a stream of signed operand pairs over a valid/ready handshake and folds each accepted pair into a running accumulator.
- Emits one result per VEC_LEN pairs over a valid/ready output handshake.
- Replaces the hand-sequenced "acc_in = acc_out" feedback loop with a self-contained front-end for the MAC array.

Parameters:
- DATA_WIDTH, 16: signed operand width.
- ACC_WIDTH, 2*DATA_WIDTH: accumulator and result width.
- VEC_LEN, 4: pairs per dot product; must be at least 1.
- CNT_WIDTH, $clog2(VEC_LEN)+1: beat counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept a pair.
- in_a  in  DATA_WIDTH  signed operand a.
- in_b  in  DATA_WIDTH  signed operand b.
- in_last  in  1  producer marks the final pair of a vector.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_WIDTH  signed dot product.
- beat_cnt  out  CNT_WIDTH  pairs accepted in the current vector.
- err_last  out  1  sticky framing error.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: in rst cycle all registers clear, so out_valid=0, out_data=0, beat_cnt=0, err_last=0, accumulator=0, state=S_FIRST. in_ready reads 1 in the first cycle after reset.
- Handshakes:
  - Input beat accepted when in_valid && in_ready.
  - Output accepted when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational).
  - The producer may hold in_valid with stable data indefinitely. Operands are sampled only on acceptance.
- Arithmetic:
  - prod = in_a * in_b, full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH.
  - Accumulation is two's-complement modulo 2^ACC_WIDTH: wrap, no saturation, no overflow flag.
- State machine (2 states):
  - S_FIRST, on accepted beat: acc <= prod, beat_cnt <= 1, go to S_ACC. If VEC_LEN==1, this is also the last beat; see below.
  - S_ACC, on accepted beat that is not last: acc <= acc + prod, beat_cnt <= beat_cnt + 1.
  - Last beat is the accepted beat with beat_cnt == VEC_LEN-1. On it: out_data <= acc + prod (prod alone from S_FIRST), out_valid <= 1, acc <= 0, beat_cnt <= 0, go to S_FIRST.
  - No accepted beat: everything holds.
- Latency: result appears one cycle after the last beat is accepted. Throughput is one pair per cycle while out_ready stays high. Back-to-back vectors need no bubble.
- Output register:
  - out_data and out_valid hold while out_valid && !out_ready.
  - out_valid clears on acceptance unless a new last beat is accepted in the same cycle. In that case out_valid stays 1 and out_data loads the new result.
- Backpressure: while a result is stalled, in_ready=0. No beats are accepted and the accumulator is frozen.
- Framing check:
  - err_last <= 1 on any accepted beat where in_last != (beat_cnt == VEC_LEN-1).
  - err_last stays set until rst. The VEC_LEN count still governs vector boundaries; in_last never resyncs them.
- Reset mid-vector: a partial accumulation and a pending result are both discarded. The next accepted beat starts a fresh vector.

Test Plan:
- VEC_LEN=3, out_ready=1; pairs (10,5), (-3,4), (7,-8) on consecutive cycles, in_last only on the third -> one cycle later out_valid=1 for exactly one cycle, out_data=-18, err_last=0.
- VEC_LEN=4; four pairs of (-32768,-32768) -> out_data=0 (wraps 4*2^30 mod 2^32). Then four pairs of (32767,32767) -> out_data=0xFFFC0004.
- VEC_LEN=3, out_ready=0 after the first result (-18):
  - out_data holds -18 for 5 cycles; in_ready=0 and in_valid with (1,1) is not accepted.
  - Raise out_ready -> result taken, then three (1,1) pairs -> out_data=3.
- VEC_LEN=3, two vectors streamed with no gap, (1,2)x3 then (2,2)x3, out_ready=1 -> out_data=6 then 12 on consecutive-vector cycles; in_ready stays 1 throughout.
- VEC_LEN=3; accept (10,5), (-3,4), then assert rst for one cycle:
  - out_valid=0, beat_cnt=0.
  - Next (7,-8), (1,1), (1,1) -> out_data=-54.
- VEC_LEN=3; in_last asserted on the second beat -> err_last=1 from the next cycle and stays set. The result is still issued after the third beat with the correct sum.
